// File: rtl/ysyx_22050550_ifu_pkg.sv
// Shared widths, FSM state encoding and word-select helper for the instruction fetch unit.
// Combinational helpers only; no latency, no backpressure.
package ysyx_22050550_ifu_pkg;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int INST_W = 32;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_DROP = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_t;

    // Picks the 32-bit half of a 64-bit memory word addressed by pc[2].
    function automatic logic [INST_W-1:0] sel_word(input logic [DATA_W-1:0] word, input logic hi);
        return hi ? word[2*INST_W-1:INST_W] : word[INST_W-1:0];
    endfunction
endpackage

// File: rtl/ysyx_22050550_ifu_if.sv
// Bundles the IFU's PC, instruction-memory and decode-side signals.
// Wires only; no latency; handshake semantics are owned by the IFU.
interface ysyx_22050550_ifu_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int INST_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              flush;
    logic              pc_adv;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              id_ready;
    logic              inst_fault;

    modport master (
        input  pc_in, flush, mem_gnt, mem_rvalid, mem_rdata, id_ready,
        output pc_adv, mem_req, mem_addr, inst_valid, inst, inst_pc, inst_fault
    );

    modport slave (
        output pc_in, flush, mem_gnt, mem_rvalid, mem_rdata, id_ready,
        input  pc_adv, mem_req, mem_addr, inst_valid, inst, inst_pc, inst_fault
    );
endinterface

// File: rtl/ysyx_22050550_ifu_wsel.sv
// Selects the instruction half of a 64-bit fetch word using pc[2].
// Purely combinational; no backpressure.
module ysyx_22050550_ifu_wsel
    import ysyx_22050550_ifu_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic              hi,
    output logic [INST_W-1:0] inst
);
    assign inst = sel_word(rdata, hi);
endmodule

// File: rtl/ysyx_22050550_ifu.sv
// Instruction fetch unit: one outstanding req/gnt/rvalid fetch, flush-safe, valid/ready to decode.
// Latency: grant -> inst_valid one cycle after rvalid; held until id_ready or flush. Optional YSYX_22050550_IFU_MISALIGN_EN.
module ysyx_22050550_ifu
    import ysyx_22050550_ifu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    ysyx_22050550_ifu_if.master   bus
);
    ifu_state_t        state;
    logic              started;
    logic [ADDR_W-1:0] pc_r;
    logic [INST_W-1:0] inst_r;
    logic              fault_r;
    logic [INST_W-1:0] sel_inst;
    logic              idle_act;
    logic              misalign;

    ysyx_22050550_ifu_wsel u_wsel (
        .rdata (bus.mem_rdata),
        .hi    (pc_r[2]),
        .inst  (sel_inst)
    );

`ifdef YSYX_22050550_IFU_MISALIGN_EN
    assign misalign = |bus.pc_in[1:0];
`else
    assign misalign = 1'b0;
`endif

    // started holds the first request off until one edge after reset release
    assign idle_act       = started && (state == IFU_IDLE);
    assign bus.mem_req    = idle_act && !misalign;
    assign bus.pc_adv     = bus.mem_req && bus.mem_gnt;
    assign bus.mem_addr   = bus.mem_req ? {bus.pc_in[ADDR_W-1:3], 3'b000} : '0;
    assign bus.inst_valid = (state == IFU_HOLD);
    assign bus.inst       = inst_r;
    assign bus.inst_pc    = pc_r;
    assign bus.inst_fault = fault_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IFU_IDLE;
            started <= 1'b0;
            pc_r    <= '0;
            inst_r  <= '0;
            fault_r <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                IFU_IDLE: begin
                    if (idle_act) begin
                        if (misalign) begin
                            pc_r    <= bus.pc_in;
                            inst_r  <= '0;
                            fault_r <= 1'b1;
                            state   <= IFU_HOLD;
                        end else if (bus.mem_gnt) begin
                            // a coincident flush is already reflected in pc_in
                            pc_r  <= bus.pc_in;
                            state <= IFU_WAIT;
                        end
                    end
                end
                IFU_WAIT: begin
                    if (bus.mem_rvalid) begin
                        if (bus.flush) begin
                            state <= IFU_IDLE;
                        end else begin
                            inst_r <= sel_inst;
                            state  <= IFU_HOLD;
                        end
                    end else if (bus.flush) begin
                        state <= IFU_DROP;
                    end
                end
                IFU_DROP: begin
                    if (bus.mem_rvalid) state <= IFU_IDLE;
                end
                IFU_HOLD: begin
                    if (bus.flush || bus.id_ready) begin
                        fault_r <= 1'b0;
                        state   <= IFU_IDLE;
                    end
                end
                default: state <= IFU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050550_ifu.sv
// Scoreboard bench for ysyx_22050550_ifu: transaction-level fetch model plus a random memory responder.
module tb_ysyx_22050550_ifu;
    import ysyx_22050550_ifu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    ysyx_22050550_ifu_if bus ();

    ysyx_22050550_ifu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // transaction model: started, fetch outstanding, flushed while outstanding, instruction held
    bit          m_started = 0;
    bit          m_out     = 0;
    bit          m_flushed = 0;
    bit          m_hold    = 0;
    logic [63:0] m_pc      = '0;

    // memory responder
    bit          mem_pend  = 0;
    int          mem_dly   = 0;
    logic [63:0] mem_data  = '0;
    int          next_dly  = -1;
    bit          next_set  = 0;
    logic [63:0] next_data = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    task automatic step(input logic [63:0] pc, input bit fl, input bit rdy, input bit gnt_en);
        bit rv, exp_req, granted, mis;
        @(negedge clock);
        rv = mem_pend && (mem_dly == 0);
        bus.pc_in      = pc;
        bus.flush      = fl;
        bus.id_ready   = rdy;
        bus.mem_rvalid = rv;
        bus.mem_rdata  = rv ? mem_data : {$urandom, $urandom};
        bus.mem_gnt    = gnt_en;
        #1;
`ifdef YSYX_22050550_IFU_MISALIGN_EN
        mis = (pc[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        exp_req = m_started && !m_out && !m_hold && !mis;
        chk("mem_req", 64'(bus.mem_req), 64'(exp_req));
        chk("pc_adv", 64'(bus.pc_adv), 64'(exp_req && gnt_en));
        if (exp_req) chk("mem_addr", bus.mem_addr, {pc[63:3], 3'b000});
        granted = exp_req && gnt_en;
        if (granted) begin
            m_out = 1; m_flushed = 0; m_pc = pc;
        end else if (m_started && !m_out && !m_hold && mis) begin
            m_hold = 1;
            sbq.push_back('{pc: pc, inst: 32'h0, fault: 1'b1});
        end else if (m_out) begin
            if (fl) m_flushed = 1;
            if (rv) begin
                m_out = 0;
                if (!m_flushed) begin
                    m_hold = 1;
                    sbq.push_back('{pc: m_pc, inst: (m_pc[2] ? mem_data[63:32] : mem_data[31:0]), fault: 1'b0});
                end
            end
        end else if (m_hold && (fl || rdy)) begin
            m_hold = 0;
        end
        m_started = 1;
        if (rv) mem_pend = 0;
        else if (mem_pend) mem_dly--;
        if (granted) begin
            mem_pend = 1;
            mem_dly  = (next_dly >= 0) ? next_dly : int'($urandom_range(0, 3));
            mem_data = next_set ? next_data : {$urandom, $urandom};
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((m_out || m_hold || mem_pend) && n < 50) begin
            step(64'h8000_0000, 1'b0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL drain_timeout: unit still busy after %0d cycles", n);
        end
    endtask

    task automatic fetch1(input logic [63:0] pc, input logic [63:0] data, input int dly,
                          input int flush_at, input int stall);
        int k;
        next_set = 1; next_data = data; next_dly = dly;
        step(pc, flush_at == 0, 1'b0, 1'b1);
        k = 1;
        while ((m_out || m_hold || mem_pend) && k < 50) begin
            step(pc + 64'h100, k == flush_at, k > stall, 1'b0);
            k++;
        end
        if (k >= 50) begin
            checks++;
            $display("FAIL fetch_timeout: pc %h still busy", pc);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_pc_adv", 64'(bus.pc_adv), 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_inst", 64'(bus.inst), 64'd0);
        chk("rst_inst_pc", bus.inst_pc, 64'd0);
        chk("rst_inst_fault", 64'(bus.inst_fault), 64'd0);
    endtask

    // monitor: pops one expectation per presented instruction and checks it stays stable
    exp_t cur;
    bit   prev_v = 0;
    bit   cur_ok = 0;
    always begin
        @(negedge clock);
        #3;
        if (!reset) begin
            prev_v = 0;
        end else if (bus.inst_valid) begin
            if (!prev_v) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_inst_valid", 64'(bus.inst_valid), 64'd0);
                    cur_ok = 0;
                end else begin
                    cur    = sbq.pop_front();
                    cur_ok = 1;
                end
            end
            if (cur_ok) begin
                chk("inst", 64'(bus.inst), 64'(cur.inst));
                chk("inst_pc", bus.inst_pc, cur.pc);
                chk("inst_fault", 64'(bus.inst_fault), 64'(cur.fault));
            end
            prev_v = 1;
        end else begin
            prev_v = 0;
        end
    end

    initial begin
        bus.pc_in = '0; bus.flush = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
        bus.mem_rdata = '0; bus.id_ready = 0;
        #2;
        check_reset_outputs();
        @(posedge clock);
        #1 reset = 1'b1;
        step(64'h8000_0000, 1'b0, 1'b0, 1'b0);

        fetch1(64'h8000_0000, 64'h00100073_00000413, 1, -1, 0);
        fetch1(64'h8000_0004, 64'hDEADBEEF_00000013, 1, -1, 0);
        fetch1(64'h8000_000C, 64'h11223344_55667788, 0, -1, 8);
        fetch1(64'h8000_0010, 64'hAAAA5555_12345678, 3, 1, 0);
        fetch1(64'h8000_0100, 64'h0BADF00D_CAFEF00D, 1, -1, 0);
        fetch1(64'h8000_0200, 64'h87654321_0FEDCBA9, 1, 0, 0);
        fetch1(64'h8000_0024, 64'h13572468_24681357, 0, 1, 0);
        fetch1(64'h8000_0028, 64'h99998888_77776666, 0, 2, 5);

        // async reset while a fetch is outstanding; its late rvalid must be ignored
        next_set = 1; next_data = 64'hFFFF0000_FFFF0000; next_dly = 3;
        step(64'h8000_0300, 1'b0, 1'b1, 1'b1);
        step(64'h8000_0300, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        m_started = 0; m_out = 0; m_hold = 0; m_flushed = 0;
        sbq.delete();
        @(posedge clock);
        #1 reset = 1'b1;
        drain();
        fetch1(64'h8000_0400, 64'h00000013_00000093, 1, -1, 0);

`ifdef YSYX_22050550_IFU_MISALIGN_EN
        step(64'h8000_0002, 1'b0, 1'b0, 1'b1);
        step(64'h8000_0002, 1'b0, 1'b0, 1'b0);
        step(64'h8000_0002, 1'b1, 1'b0, 1'b0);
        drain();
`endif

        next_set = 0; next_dly = -1;
        for (int i = 0; i < 400; i++) begin
            logic [63:0] pc;
            pc = 64'h8000_0000 | (64'($urandom_range(0, 255)) << 2);
            step(pc, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                 !mem_pend && ($urandom_range(0, 1) == 1));
        end
        drain();
        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_22050550_ifu.md
Name: ysyx_22050550_ifu

Overview:
Instruction fetch unit directly downstream of the PC register. Takes the PC register's next-PC output, issues one fetch at a time on a req/gnt/rvalid instruction-memory port and selects the 32-bit instruction from the 64-bit return word. Presents {inst, inst_pc} to decode with a valid/ready handshake. Pulses `pc_adv` back into the PC register's `ready` input when a fetch is granted. Handles redirect flushes by discarding stale responses.

Parameters:
ADDR_W, 64, PC / memory address width
DATA_W, 64, memory read-data width
INST_W, 32, instruction width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
pc_in  in  ADDR_W  next PC from the PC register (already redirect-muxed)
flush  in  1  redirect from decode (jump flag nonzero and decode valid)
pc_adv  out  1  one-cycle pulse to the PC register's `ready` input: fetch granted
mem_req  out  1  fetch request
mem_addr  out  ADDR_W  fetch address, {pc_in[ADDR_W-1:3], 3'b000}
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid; exactly one per grant, at least 1 cycle after the grant
mem_rdata  in  DATA_W  read data
inst_valid  out  1  instruction valid to decode
inst  out  INST_W  instruction
inst_pc  out  ADDR_W  PC of `inst`
id_ready  in  1  decode accepts the instruction
inst_fault  out  1  misalignment fault qualifier; only with the optional feature, otherwise tied 0

Behaviour:
- Reset (reset==0, async): state=IDLE, pc_r=0, inst_r=0, all outputs 0. On deassertion, fetching starts the next clock edge.
- States: IDLE, WAIT, DROP, HOLD.
- IDLE:
  - mem_req=1; mem_addr follows pc_in combinationally.
  - On mem_req&mem_gnt: pc_adv=1 (combinational, same cycle), latch pc_r<=pc_in, go WAIT.
  - A flush in the same cycle as a grant does NOT cancel it: pc_in already carries the redirect target.
  - Memory samples the address only on a grant, so the address may change while ungranted.
- WAIT: mem_req=0.
  - rvalid & !flush: inst_r<=pc_r[2] ? rdata[63:32] : rdata[31:0]; go HOLD.
  - rvalid & flush: discard, go IDLE.
  - !rvalid & flush: go DROP.
- DROP: mem_req=0. On rvalid, discard and go IDLE. Further flushes are ignored.
- HOLD: inst_valid=1, inst=inst_r, inst_pc=pc_r; stable until accepted.
  - id_ready & !flush: go IDLE.
  - flush (any id_ready): drop the instruction, go IDLE.
- pc_adv is asserted only in IDLE on a grant; it is never asserted in WAIT, DROP or HOLD.
- Minimum latency, grant to inst_valid: 1 cycle after rvalid. Throughput is at most one instruction per 3 cycles (no overlapping requests).
- The unit never issues a second request before the outstanding rvalid has been consumed.
- Reset mid-transaction: return to IDLE immediately; an rvalid arriving after reset in IDLE is ignored.

Optional Feature:
Macro YSYX_22050550_IFU_MISALIGN_EN.
- Defined: in IDLE, if pc_in[1:0]!=0, no request is issued and pc_adv stays 0. Go directly to HOLD with pc_r=pc_in, inst_r=0, inst_fault=1. A later flush clears the fault.
- Undefined: inst_fault tied 0. Address bits [1:0] are ignored; the word is selected by bit 2 only.

Decomposition:
- Shared define file gets the state encodings (IFU_IDLE=2'd0, IFU_WAIT=2'd1, IFU_DROP=2'd2, IFU_HOLD=2'd3) and the INST_W constant. The existing register-width macro is reused for ADDR_W/DATA_W.
- One natural sub-module: ysyx_22050550_ifu_wsel, a combinational word selector (rdata, pc[2] -> inst).
- State and data registers use the team's async-reset register style, not the synchronous-reset register helper.

Test Plan:
- Basic fetch: release reset, pc_in=0x80000000, gnt on first req cycle, rvalid 2 cycles later with rdata=0x00100073_00000413, id_ready=1 -> pc_adv pulses once; inst_valid=1 with inst=0x00000413, inst_pc=0x80000000.
- Upper word: pc_in=0x80000004, rdata=0xDEADBEEF_00000013 -> inst=0xDEADBEEF, mem_addr=0x80000000.
- Decode stall: id_ready=0 for 5 cycles -> inst_valid, inst and inst_pc stable for 5 cycles; no mem_req, no pc_adv until acceptance.
- Flush in WAIT: flush 1 cycle after grant, rvalid 3 cycles later -> state DROP, response discarded, inst_valid never asserted, next req at the new pc_in=0x80000100.
- Flush coincident with grant in IDLE: pc_in=0x80000200 at grant with flush=1 -> request kept, inst_pc=0x80000200 delivered.
- Async reset during WAIT, then late rvalid after release -> outputs 0, rvalid ignored, fresh request issued; with the macro defined, pc_in=0x80000002 -> inst_fault=1, no mem_req.
